instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the program counter. Takes the current pc, reads the

---
 rtl/puc_pkg.sv | 21 ++
 rtl/fetch_line_buffer.sv | 47 ++++
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puc_pkg.sv
// Shared opcode encodings, fetch FSM state type and default field widths for the PUC core.
// Pure declarations: no latency, no flow control.
package puc_pkg;

  localparam int DEF_OPCODE_WIDTH = 4;
  localparam int DEF_VALUE_WIDTH  = 8;

  localparam logic [DEF_OPCODE_WIDTH-1:0] RET     = 4'd0;
  localparam logic [DEF_OPCODE_WIDTH-1:0] CALL    = 4'd1;
  localparam logic [DEF_OPCODE_WIDTH-1:0] JUMP    = 4'd2;
  localparam logic [DEF_OPCODE_WIDTH-1:0] IF0JUMP = 4'd3;
  localparam logic [DEF_OPCODE_WIDTH-1:0] IF1JUMP = 4'd4;
  localparam logic [DEF_OPCODE_WIDTH-1:0] RESET   = 4'd5;

  typedef enum logic [1:0] {
    S_RESET,
    S_REQ,
    S_WAIT
  } fetch_state_t;

endpackage

// File: rtl/fetch_line_buffer.sv
// One-entry last-instruction buffer: combinational hit compare, single-cycle load.
// Never invalidated except by reset; instruction memory is read-only.
module fetch_line_buffer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = load_addr_i;
      data_d  = load_data_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (addr_q == lookup_addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage ahead of the PC: one outstanding memory read, outputs combinational (zero added latency).
// While a fetch is pending it drives JUMP to the current pc so the stall-less PC holds in place.
module instruction_fetch
  import puc_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  parameter int VALUE_WIDTH  = DEF_VALUE_WIDTH,
  parameter int INSTR_WIDTH  = OPCODE_WIDTH + VALUE_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [PC_WIDTH-1:0]     pc,
  output logic                    mem_req_valid,
  output logic [PC_WIDTH-1:0]     mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]  mem_rsp_data,
  output logic [OPCODE_WIDTH-1:0] resetCode,
  output logic [VALUE_WIDTH-1:0]  instructionValue,
  output logic                    fetch_error
);

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic                  err_q, err_d;

  logic                  buf_hit;
  logic                  buf_load;
  logic [INSTR_WIDTH-1:0] buf_instr;

  fetch_line_buffer #(
    .ADDR_WIDTH (PC_WIDTH),
    .DATA_WIDTH (INSTR_WIDTH)
  ) u_line_buffer (
    .clock         (clock),
    .reset         (reset),
    .lookup_addr_i (pc),
    .hit_o         (buf_hit),
    .data_o        (buf_instr),
    .load_i        (buf_load),
    .load_addr_i   (req_addr_q),
    .load_data_i   (mem_rsp_data)
  );

  always_comb begin
    state_d          = state_q;
    req_addr_d       = req_addr_q;
    err_d            = err_q;
    buf_load         = 1'b0;
    mem_req_valid    = 1'b0;
    resetCode        = OPCODE_WIDTH'(RESET);
    instructionValue = '0;

    case (state_q)
      S_RESET: begin
        state_d = S_REQ;
        if (mem_rsp_valid) err_d = 1'b1;
      end

      S_REQ: begin
        // Only one request is ever outstanding, so a response here has no owner.
        if (mem_rsp_valid) err_d = 1'b1;
        if (buf_hit) begin
          resetCode        = buf_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
          instructionValue = buf_instr[VALUE_WIDTH-1:0];
        end else begin
          mem_req_valid    = 1'b1;
          resetCode        = OPCODE_WIDTH'(JUMP);
          instructionValue = VALUE_WIDTH'(pc);
          if (mem_req_ready) begin
            req_addr_d = pc;
            state_d    = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (mem_rsp_valid) begin
          resetCode        = mem_rsp_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];
          instructionValue = mem_rsp_data[VALUE_WIDTH-1:0];
          buf_load         = 1'b1;
          state_d          = S_REQ;
        end else begin
          resetCode        = OPCODE_WIDTH'(JUMP);
          instructionValue = VALUE_WIDTH'(req_addr_q);
        end
      end

      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_RESET;
      req_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_addr = pc;
  assign fetch_error  = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: directed per-cycle expectations, then a PC-model program run.
`timescale 1ns/1ps
module tb_instruction_fetch;
  import puc_pkg::*;

  localparam logic [3:0] ALU6 = 4'd6;
  localparam logic [3:0] ALU7 = 4'd7;
  localparam logic [3:0] ALU8 = 4'd8;
  localparam logic [3:0] ALU9 = 4'd9;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic        mem_req_valid;
  logic [7:0]  mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [11:0] mem_rsp_data;
  logic [3:0]  resetCode;
  logic [7:0]  instructionValue;
  logic        fetch_error;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock            (clock),
    .reset            (reset),
    .pc               (pc),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_ready    (mem_req_ready),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .resetCode        (resetCode),
    .instructionValue (instructionValue),
    .fetch_error      (fetch_error)
  );

  // Directed drive vs. model drive, selected per phase.
  logic        pc_auto, mem_auto;
  logic [7:0]  man_pc;
  logic        man_ready, man_rsp_v;
  logic [11:0] man_rsp_d;
  logic [7:0]  model_pc;
  logic        auto_ready, auto_rsp_v;
  logic [11:0] auto_rsp_d;

  assign pc            = pc_auto  ? model_pc   : man_pc;
  assign mem_req_ready = mem_auto ? auto_ready : man_ready;
  assign mem_rsp_valid = mem_auto ? auto_rsp_v : man_rsp_v;
  assign mem_rsp_data  = mem_auto ? auto_rsp_d : man_rsp_d;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] val;
    logic       rv;
    logic [7:0] addr;
    logic       err;
  } cyc_t;

  cyc_t        exp_cyc[$];
  logic [11:0] exp_exec[$];
  logic [11:0] prog [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Memory model: accepts on valid&ready, answers after 1..8 cycles.
  logic       acc_s, rsp_s, outstanding;
  logic [7:0] addr_s, out_addr;
  int         lat;
  initial begin
    outstanding = 1'b0;
    auto_ready  = 1'b0;
    auto_rsp_v  = 1'b0;
    auto_rsp_d  = '0;
    lat         = 0;
    out_addr    = '0;
  end
  always begin
    @(negedge clock);
    acc_s  = mem_req_valid && mem_req_ready;
    rsp_s  = mem_rsp_valid;
    addr_s = mem_req_addr;
    @(posedge clock);
    #1;
    if (!mem_auto || reset) begin
      outstanding = 1'b0;
      auto_rsp_v  = 1'b0;
      auto_ready  = 1'b0;
    end else begin
      if (rsp_s) begin
        outstanding = 1'b0;
        auto_rsp_v  = 1'b0;
      end
      if (acc_s) begin
        outstanding = 1'b1;
        out_addr    = addr_s;
        lat         = int'($urandom_range(1, 8));
      end
      if (outstanding && !auto_rsp_v) begin
        if (lat <= 1) begin
          auto_rsp_v = 1'b1;
          auto_rsp_d = prog[out_addr[4:0]];
        end else begin
          lat--;
        end
      end
      auto_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // PC model: RESET->0, JUMP->value, CALL/RET through a stack, anything else pc+1.
  logic [3:0] op_s;
  logic [7:0] val_s;
  logic [7:0] stack[$];
  initial model_pc = '0;
  always begin
    @(negedge clock);
    op_s  = resetCode;
    val_s = instructionValue;
    @(posedge clock);
    #1;
    if (!pc_auto) begin
      model_pc = '0;
      stack.delete();
    end else begin
      case (op_s)
        RESET: model_pc = '0;
        JUMP:  model_pc = val_s;
        CALL: begin
          stack.push_back(8'(model_pc + 8'd1));
          model_pc = val_s;
        end
        RET:     model_pc = (stack.size() != 0) ? stack.pop_back() : 8'h00;
        default: model_pc = 8'(model_pc + 8'd1);
      endcase
    end
  end

  // Monitor: per-cycle expectations, plus executed-instruction events against the golden trace.
  int   cyc_idx = 0;
  cyc_t e_c, a_c;
  logic [11:0] e_x;
  always @(negedge clock) begin
    if (exp_cyc.size() != 0) begin
      e_c = exp_cyc.pop_front();
      a_c = {resetCode, instructionValue, mem_req_valid,
             (mem_req_valid ? mem_req_addr : 8'h00), fetch_error};
      check($sformatf("cycle%0d{op,val,rv,addr,err}", cyc_idx), {10'b0, a_c}, {10'b0, e_c});
      cyc_idx++;
    end
    if (pc_auto && exp_exec.size() != 0 && resetCode != RESET && !mem_req_valid &&
        (!outstanding || mem_rsp_valid)) begin
      e_x = exp_exec.pop_front();
      check("exec{op,val}", {20'b0, resetCode, instructionValue}, {20'b0, e_x});
    end
  end

  task automatic step(input logic [3:0] op, input logic [7:0] val, input logic rv,
                      input logic [7:0] addr, input logic err);
    cyc_t c;
    c = {op, val, rv, (rv ? addr : 8'h00), err};
    exp_cyc.push_back(c);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1; pc_auto = 1'b0; mem_auto = 1'b0;
    man_pc = 8'h00; man_ready = 1'b0; man_rsp_v = 1'b0; man_rsp_d = '0;
    @(posedge clock);
    #1;

    // Reset held, then the extra RESET cycle after release, then the first request.
    repeat (3) step(RESET, 8'h00, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    step(RESET, 8'h00, 1'b0, 8'h00, 1'b0);

    // Fetch at 0 with 3-cycle response latency.
    man_ready = 1'b1; step(JUMP, 8'h00, 1'b1, 8'h00, 1'b0);
    man_ready = 1'b0; step(JUMP, 8'h00, 1'b0, 8'h00, 1'b0);
    step(JUMP, 8'h00, 1'b0, 8'h00, 1'b0);
    man_rsp_v = 1'b1; man_rsp_d = {CALL, 8'h20};
    step(CALL, 8'h20, 1'b0, 8'h00, 1'b0);
    man_rsp_v = 1'b0; man_pc = 8'h20; man_ready = 1'b1;
    step(JUMP, 8'h20, 1'b1, 8'h20, 1'b0);
    man_ready = 1'b0; man_rsp_v = 1'b1; man_rsp_d = {JUMP, 8'h05};
    step(JUMP, 8'h05, 1'b0, 8'h00, 1'b0);

    // Request stalled by ready low at pc 5.
    man_rsp_v = 1'b0; man_pc = 8'h05;
    repeat (4) step(JUMP, 8'h05, 1'b1, 8'h05, 1'b0);
    man_ready = 1'b1; step(JUMP, 8'h05, 1'b1, 8'h05, 1'b0);
    man_ready = 1'b0; step(JUMP, 8'h05, 1'b0, 8'h00, 1'b0);
    man_rsp_v = 1'b1; man_rsp_d = {JUMP, 8'h07};
    step(JUMP, 8'h07, 1'b0, 8'h00, 1'b0);

    // Self loop at 7: one memory fetch, then buffer hits with no request.
    man_rsp_v = 1'b0; man_pc = 8'h07; man_ready = 1'b1;
    step(JUMP, 8'h07, 1'b1, 8'h07, 1'b0);
    man_ready = 1'b0; step(JUMP, 8'h07, 1'b0, 8'h00, 1'b0);
    man_rsp_v = 1'b1; man_rsp_d = {JUMP, 8'h07};
    step(JUMP, 8'h07, 1'b0, 8'h00, 1'b0);
    man_rsp_v = 1'b0; man_ready = 1'b1;
    repeat (3) step(JUMP, 8'h07, 1'b0, 8'h00, 1'b0);

    // Load address 0 into the buffer, then reset mid-wait and deliver a late response.
    man_pc = 8'h00; step(JUMP, 8'h00, 1'b1, 8'h00, 1'b0);
    man_ready = 1'b0; man_rsp_v = 1'b1; man_rsp_d = {CALL, 8'h20};
    step(CALL, 8'h20, 1'b0, 8'h00, 1'b0);
    man_rsp_v = 1'b0; step(CALL, 8'h20, 1'b0, 8'h00, 1'b0);
    man_pc = 8'h10; man_ready = 1'b1; step(JUMP, 8'h10, 1'b1, 8'h10, 1'b0);
    man_ready = 1'b0; step(JUMP, 8'h10, 1'b0, 8'h00, 1'b0);
    reset = 1'b1; man_pc = 8'h00;
    repeat (2) step(RESET, 8'h00, 1'b0, 8'h00, 1'b0);
    reset = 1'b0; man_rsp_v = 1'b1; man_rsp_d = {RET, 8'h33};
    step(RESET, 8'h00, 1'b0, 8'h00, 1'b0);
    man_rsp_v = 1'b0;
    repeat (2) step(JUMP, 8'h00, 1'b1, 8'h00, 1'b1);

    // Program run with random latency against the PC model.
    for (int i = 0; i < 32; i++) prog[i] = {ALU8, 8'(i)};
    prog[5'h00] = {ALU6, 8'h01};
    prog[5'h01] = {CALL, 8'h10};
    prog[5'h02] = {ALU7, 8'h02};
    prog[5'h03] = {JUMP, 8'h14};
    prog[5'h10] = {ALU8, 8'h10};
    prog[5'h11] = {CALL, 8'h18};
    prog[5'h12] = {RET,  8'h00};
    prog[5'h14] = {ALU6, 8'h14};
    prog[5'h15] = {JUMP, 8'h1F};
    prog[5'h18] = {ALU9, 8'h18};
    prog[5'h19] = {RET,  8'h00};
    prog[5'h1F] = {JUMP, 8'h1F};
    exp_exec.push_back({ALU6, 8'h01});
    exp_exec.push_back({CALL, 8'h10});
    exp_exec.push_back({ALU8, 8'h10});
    exp_exec.push_back({CALL, 8'h18});
    exp_exec.push_back({ALU9, 8'h18});
    exp_exec.push_back({RET,  8'h00});
    exp_exec.push_back({RET,  8'h00});
    exp_exec.push_back({ALU7, 8'h02});
    exp_exec.push_back({JUMP, 8'h14});
    exp_exec.push_back({ALU6, 8'h14});
    exp_exec.push_back({JUMP, 8'h1F});
    exp_exec.push_back({JUMP, 8'h1F});
    exp_exec.push_back({JUMP, 8'h1F});
    exp_exec.push_back({JUMP, 8'h1F});

    reset = 1'b1; pc_auto = 1'b1; mem_auto = 1'b1;
    repeat (2) step(RESET, 8'h00, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    cnt = 0;
    while (exp_exec.size() != 0 && cnt < 3000) begin
      @(posedge clock);
      #1;
      cnt++;
    end
    check("program_trace_remaining", 32'(exp_exec.size()), 32'd0);
    check("program_fetch_error", {31'b0, fetch_error}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
